mc_controller: RTL and testbench

Multicycle control unit for the MIPS processor. Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback steps, driving the datapath enables, mux selects and the 3-bit `alucont` code consumed by the TMR/NMR `alu`. Sits directly upstream of the ALU and the register file. Takes the `zero` flag back from the ALU to resolve `beq`.

---
 rtl/mc_controller.sv | 202 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, producing datapath enables, mux selects and alucont.
// Ports:
//   clk, reset (async, active-high)
//   op[5:0], funct[5:0] : instruction fields from the IR
//   zero                : ALU zero flag, resolves beq
//   pcen, memwrite, irwrite, regwrite : write strobes (gated low in reset)
//   iord, alusrca, alusrcb[1:0], pcsrc[1:0], memtoreg, regdst : selects
//   alucont[2:0]        : ALU operation code
//   illegal             : pulse on unsupported opcode/funct
// All outputs are combinational decodes of the state register and inputs.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       memtoreg,
  output logic       regdst,
  output logic [2:0] alucont,
  output logic       illegal
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYP = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t state_q, state_d;

  logic       pcwrite, branch;
  logic       memwrite_r, irwrite_r, regwrite_r, iord_r, alusrca_r;
  logic       memtoreg_r, regdst_r, illegal_r;
  logic [1:0] alusrcb_r, pcsrc_r, aluop;
  logic [2:0] alucont_r, funct_alu;
  logic       funct_ok;

  // State register; reset forces FETCH without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // R-type funct decode; funct_ok flags the supported subset.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    unique case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Next-state and per-state raw control outputs.
  always_comb begin
    state_d    = state_q;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    memwrite_r = 1'b0;
    irwrite_r  = 1'b0;
    regwrite_r = 1'b0;
    iord_r     = 1'b0;
    alusrca_r  = 1'b0;
    alusrcb_r  = 2'b00;
    pcsrc_r    = 2'b00;
    memtoreg_r = 1'b0;
    regdst_r   = 1'b0;
    aluop      = 2'b00;
    illegal_r  = 1'b0;
    unique case (state_q)
      FETCH: begin
        irwrite_r = 1'b1;
        pcwrite   = 1'b1;
        alusrcb_r = 2'b01;
        state_d   = DECODE;
      end
      DECODE: begin
        alusrcb_r = 2'b11;
        unique case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default: begin
            state_d   = FETCH;
            illegal_r = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca_r = 1'b1;
        alusrcb_r = 2'b10;
        state_d   = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord_r  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        regwrite_r = 1'b1;
        memtoreg_r = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        iord_r     = 1'b1;
        memwrite_r = 1'b1;
        state_d    = FETCH;
      end
      RTYPEEX: begin
        alusrca_r = 1'b1;
        aluop     = 2'b10;
        illegal_r = ~funct_ok;
        state_d   = RTYPEWB;
      end
      RTYPEWB: begin
        // An unsupported funct completes without touching the register file.
        regwrite_r = funct_ok;
        regdst_r   = 1'b1;
        state_d    = FETCH;
      end
      BEQEX: begin
        alusrca_r = 1'b1;
        aluop     = 2'b01;
        pcsrc_r   = 2'b01;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      ADDIEX: begin
        alusrca_r = 1'b1;
        alusrcb_r = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        regwrite_r = 1'b1;
        state_d    = FETCH;
      end
      JEX: begin
        pcsrc_r = 2'b10;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // ALU control from aluop.
  always_comb begin
    alucont_r = 3'b010;
    unique case (aluop)
      2'b01:   alucont_r = 3'b110;
      2'b10:   alucont_r = funct_alu;
      default: alucont_r = 3'b010;
    endcase
  end

  // Reset gating is combinational so strobes drop the instant reset rises.
  assign pcen     = ~reset & (pcwrite | (branch & zero));
  assign memwrite = ~reset & memwrite_r;
  assign irwrite  = ~reset & irwrite_r;
  assign regwrite = ~reset & regwrite_r;
  assign illegal  = ~reset & illegal_r;
  assign iord     = ~reset & iord_r;
  assign alusrca  = ~reset & alusrca_r;
  assign memtoreg = ~reset & memtoreg_r;
  assign regdst   = ~reset & regdst_r;
  assign alusrcb  = reset ? 2'b00 : alusrcb_r;
  assign pcsrc    = reset ? 2'b00 : pcsrc_r;
  assign alucont  = reset ? 3'b010 : alucont_r;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed vector table, hand-written
// reset/branch sequences, and random instructions against an
// instruction-level reference model.
module tb_mc_controller;

  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       memtoreg;
    logic       regdst;
    logic [2:0] alucont;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         lat;
    int         chk;
    outs_t      exp;
  } vec_t;

  logic       clk, reset, zero;
  logic [5:0] op, funct;
  logic       pcen, memwrite, irwrite, regwrite, iord, alusrca, memtoreg, regdst, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucont;
  outs_t      act;

  int errors = 0;
  int checks = 0;
  outs_t exp_q[$];
  vec_t  tbl[$];

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .memtoreg(memtoreg), .regdst(regdst), .alucont(alucont), .illegal(illegal)
  );

  assign act = {pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
                pcsrc, memtoreg, regdst, alucont, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t o(input logic pe, mw, iw, rw, id, sa,
                              input logic [1:0] sb, ps,
                              input logic mr, rd,
                              input logic [2:0] ac,
                              input logic il);
    return {pe, mw, iw, rw, id, sa, sb, ps, mr, rd, ac, il};
  endfunction

  function automatic vec_t v(input logic [5:0] op_i, funct_i, input logic z,
                             input int lat, chk, input outs_t e);
    vec_t r;
    r.op = op_i; r.funct = funct_i; r.zero = z; r.lat = lat; r.chk = chk; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Reference: what each clock of one instruction should look like.
  function automatic logic [2:0] alu_for_funct(input logic [5:0] f, output logic ok);
    ok = 1'b1;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: begin ok = 1'b0; return 3'b010; end
    endcase
  endfunction

  task automatic build_exp(input logic [5:0] op_i, funct_i, input logic z);
    logic ok;
    logic [2:0] ac;
    logic legal_op;
    legal_op = op_i inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    exp_q = {};
    exp_q.push_back(o(1,0,1,0,0,0,2'b01,2'b00,0,0,3'b010,0));
    exp_q.push_back(o(0,0,0,0,0,0,2'b11,2'b00,0,0,3'b010,!legal_op));
    case (op_i)
      6'b100011: begin
        exp_q.push_back(o(0,0,0,0,0,1,2'b10,2'b00,0,0,3'b010,0));
        exp_q.push_back(o(0,0,0,0,1,0,2'b00,2'b00,0,0,3'b010,0));
        exp_q.push_back(o(0,0,0,1,0,0,2'b00,2'b00,1,0,3'b010,0));
      end
      6'b101011: begin
        exp_q.push_back(o(0,0,0,0,0,1,2'b10,2'b00,0,0,3'b010,0));
        exp_q.push_back(o(0,1,0,0,1,0,2'b00,2'b00,0,0,3'b010,0));
      end
      6'b000000: begin
        ac = alu_for_funct(funct_i, ok);
        exp_q.push_back(o(0,0,0,0,0,1,2'b00,2'b00,0,0,ac,!ok));
        exp_q.push_back(o(0,0,0,ok,0,0,2'b00,2'b00,0,1,3'b010,0));
      end
      6'b000100: exp_q.push_back(o(z,0,0,0,0,1,2'b00,2'b01,0,0,3'b110,0));
      6'b001000: begin
        exp_q.push_back(o(0,0,0,0,0,1,2'b10,2'b00,0,0,3'b010,0));
        exp_q.push_back(o(0,0,0,1,0,0,2'b00,2'b00,0,0,3'b010,0));
      end
      6'b000010: exp_q.push_back(o(1,0,0,0,0,0,2'b00,2'b10,0,0,3'b010,0));
      default: ;
    endcase
  endtask

  // Runs one instruction starting in FETCH before its rising edge; ends at
  // the negedge of the following FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op_i, funct_i, input logic z);
    op = op_i; funct = funct_i; zero = z;
    build_exp(op_i, funct_i, z);
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("%s.c%0d", tag, i), act, exp_q[i]);
    end
    @(negedge clk);
  endtask

  localparam logic [5:0] LEGAL_OPS [6] = '{6'b100011, 6'b101011, 6'b000000,
                                           6'b000100, 6'b001000, 6'b000010};
  localparam logic [5:0] LEGAL_FN  [5] = '{6'b100000, 6'b100010, 6'b100100,
                                           6'b100101, 6'b101010};

  outs_t rst_vec, fetch_vec;

  initial begin
    rst_vec   = o(0,0,0,0,0,0,2'b00,2'b00,0,0,3'b010,0);
    fetch_vec = o(1,0,1,0,0,0,2'b01,2'b00,0,0,3'b010,0);

    tbl.push_back(v(6'b100011, 6'd0, 0, 5, 0, fetch_vec));
    tbl.push_back(v(6'b100011, 6'd0, 0, 5, 2, o(0,0,0,0,0,1,2'b10,2'b00,0,0,3'b010,0)));
    tbl.push_back(v(6'b100011, 6'd0, 0, 5, 4, o(0,0,0,1,0,0,2'b00,2'b00,1,0,3'b010,0)));
    tbl.push_back(v(6'b000000, 6'b100010, 0, 4, 2, o(0,0,0,0,0,1,2'b00,2'b00,0,0,3'b110,0)));
    tbl.push_back(v(6'b000000, 6'b101010, 0, 4, 2, o(0,0,0,0,0,1,2'b00,2'b00,0,0,3'b111,0)));
    tbl.push_back(v(6'b000000, 6'b100101, 0, 4, 2, o(0,0,0,0,0,1,2'b00,2'b00,0,0,3'b001,0)));
    tbl.push_back(v(6'b000000, 6'b100100, 0, 4, 2, o(0,0,0,0,0,1,2'b00,2'b00,0,0,3'b000,0)));
    tbl.push_back(v(6'b000000, 6'b100000, 0, 4, 3, o(0,0,0,1,0,0,2'b00,2'b00,0,1,3'b010,0)));
    tbl.push_back(v(6'b000100, 6'd0, 1, 3, 2, o(1,0,0,0,0,1,2'b00,2'b01,0,0,3'b110,0)));
    tbl.push_back(v(6'b000100, 6'd0, 0, 3, 2, o(0,0,0,0,0,1,2'b00,2'b01,0,0,3'b110,0)));
    tbl.push_back(v(6'b101011, 6'd0, 0, 4, 3, o(0,1,0,0,1,0,2'b00,2'b00,0,0,3'b010,0)));
    tbl.push_back(v(6'b000010, 6'd0, 0, 3, 2, o(1,0,0,0,0,0,2'b00,2'b10,0,0,3'b010,0)));
    tbl.push_back(v(6'b111111, 6'd0, 0, 2, 1, o(0,0,0,0,0,0,2'b11,2'b00,0,0,3'b010,1)));
    tbl.push_back(v(6'b000000, 6'b000111, 0, 4, 2, o(0,0,0,0,0,1,2'b00,2'b00,0,0,3'b010,1)));
    tbl.push_back(v(6'b000000, 6'b000111, 0, 4, 3, o(0,0,0,0,0,0,2'b00,2'b00,0,1,3'b010,0)));
    tbl.push_back(v(6'b001000, 6'd0, 0, 4, 3, o(0,0,0,1,0,0,2'b00,2'b00,0,0,3'b010,0)));

    // Reset held across clock edges: everything gated.
    reset = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", act, rst_vec);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: one check per entry plus measured latency.
    foreach (tbl[k]) begin
      int c;
      outs_t lat_got, lat_want;
      op = tbl[k].op; funct = tbl[k].funct; zero = tbl[k].zero;
      #1;
      c = 0;
      while (c < 12) begin
        if (c == tbl[k].chk) check($sformatf("tbl%0d.cyc%0d", k, c), act, tbl[k].exp);
        if (c > 0 && irwrite === 1'b1) break;
        @(negedge clk);
        #1;
        c++;
      end
      lat_got = outs_t'(c); lat_want = outs_t'(tbl[k].lat);
      check($sformatf("tbl%0d.latency", k), lat_got, lat_want);
      @(negedge clk);
      // Table loop leaves us in the cycle after FETCH; realign to FETCH.
      while (irwrite !== 1'b1 && c < 24) begin @(negedge clk); c++; end
    end

    // beq: pcen tracks zero within the BEQEX cycle.
    op = 6'b000100; funct = 6'd0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("beq_z0", act, o(0,0,0,0,0,1,2'b00,2'b01,0,0,3'b110,0));
    zero = 1'b1;
    #1 check("beq_z_rise", act, o(1,0,0,0,0,1,2'b00,2'b01,0,0,3'b110,0));
    @(negedge clk);
    #1 check("beq_back_fetch", act, fetch_vec);

    // Reset mid-MEMWB: strobe drops asynchronously, FSM restarts in FETCH
    // with no clock edge in between.
    op = 6'b100011; funct = 6'd0; zero = 1'b0;
    repeat (4) @(negedge clk);
    #1 check("memwb_pre_reset", act, o(0,0,0,1,0,0,2'b00,2'b00,1,0,3'b010,0));
    #1 reset = 1'b1;
    #1 check("memwb_in_reset", act, rst_vec);
    reset = 1'b0;
    run_instr("post_reset_lw", 6'b100011, 6'd0, 1'b0);

    // Random instructions against the reference model.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] rop, rfn;
      int sel;
      sel = $urandom_range(0, 7);
      rop = (sel < 6) ? LEGAL_OPS[sel] : (sel == 6 ? 6'($urandom) : 6'b000000);
      rfn = ($urandom_range(0, 1) == 0) ? LEGAL_FN[$urandom_range(0, 4)] : 6'($urandom);
      run_instr($sformatf("rand%0d_op%b", n, rop), rop, rfn, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
